stream_upsizer: RTL and testbench

Downstream consumer of the single-stage pipeline register. It accepts DATA_WIDTH-bit beats over a valid/ready handshake and packs RATIO consecutive beats into one wide word. It can also flush a partial word early on `in_last`, marking the filled lanes with a keep mask. It feeds wide datapaths, such as memory write ports or bus bridges, that consume whole words.

---
 rtl/stream_pkg.sv | 20 ++
 rtl/stream_upsizer.sv | 141 ++++++++++++++
 tb/tb_stream_upsizer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared constants and helpers for the stream width converters.
package stream_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefRatio     = 4;
  localparam int unsigned MaxRatio     = 16;

  // Mask with the lowest `lanes` bits set.
  function automatic logic [MaxRatio-1:0] keep_mask(input int unsigned lanes);
    logic [MaxRatio-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < MaxRatio; i++) begin
      if (i < lanes) begin
        mask[i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow beats into one wide word, with early flush on in_last.
module stream_upsizer
  import stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned RATIO      = DefRatio
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [DATA_WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]            out_keep,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int unsigned CntW = $clog2(RATIO);
  localparam int unsigned AccW = (RATIO - 1) * DATA_WIDTH;
  localparam int unsigned OutW = DATA_WIDTH * RATIO;

  if (RATIO < 2 || RATIO > MaxRatio) begin : g_bad_ratio
    $error("stream_upsizer: RATIO must be in 2..16");
  end

  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [AccW-1:0]        acc_q, acc_d;
  logic [RATIO-2:0]       acc_keep_q, acc_keep_d;
  logic [OutW-1:0]        out_data_q, out_data_d;
  logic [RATIO-1:0]       out_keep_q, out_keep_d;
  logic                   out_last_q, out_last_d;
  logic                   out_valid_q, out_valid_d;

  logic                   accept;
  logic                   last_lane;
  logic                   complete;
  logic [OutW-1:0]        word_data;
  logic [MaxRatio-1:0]    keep_full;
  logic                   unused_keep;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign last_lane = (cnt_q == CntW'(RATIO - 1));
  assign complete  = accept && (last_lane || in_last);

  assign keep_full   = keep_mask(32'(cnt_q) + 32'd1);
  assign unused_keep = ^keep_full;

  // Stale acc lanes beyond the current fill are masked out by acc_keep_q.
  always_comb begin
    word_data = '0;
    for (int k = 0; k < int'(RATIO) - 1; k++) begin
      if (acc_keep_q[k]) begin
        word_data[k*DATA_WIDTH +: DATA_WIDTH] = acc_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    for (int k = 0; k < int'(RATIO); k++) begin
      if (cnt_q == CntW'(k)) begin
        word_data[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = complete ? '0 : cnt_q + CntW'(1);
    end
  end

  always_comb begin
    acc_d      = acc_q;
    acc_keep_d = acc_keep_q;
    if (complete) begin
      acc_keep_d = '0;
    end else if (accept) begin
      for (int k = 0; k < int'(RATIO) - 1; k++) begin
        if (cnt_q == CntW'(k)) begin
          acc_d[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
          acc_keep_d[k]                     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    if (complete) begin
      out_data_d  = word_data;
      out_keep_d  = keep_full[RATIO-1:0];
      out_last_d  = in_last;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q      <= '0;
      acc_keep_q <= '0;
    end else begin
      acc_q      <= acc_d;
      acc_keep_q <= acc_keep_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed bench for stream_upsizer with a queue of expected output words.
module tb_stream_upsizer;

  localparam int unsigned DW = 8;
  localparam int unsigned R  = 4;

  typedef struct packed {
    logic [DW*R-1:0] data;
    logic [R-1:0]    keep;
    logic            last;
  } word_t;

  logic            clk;
  logic            reset_n;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic [DW*R-1:0] out_data;
  logic [R-1:0]    out_keep;
  logic            out_last;
  logic            out_valid;
  logic            out_ready;

  word_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    words  = 0;

  stream_upsizer #(
    .DATA_WIDTH(DW),
    .RATIO     (R)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_keep (out_keep),
    .out_last (out_last),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_word(input logic [DW*R-1:0] d, input logic [R-1:0] k, input logic l);
    word_t w;
    w.data = d;
    w.keep = k;
    w.last = l;
    exp_q.push_back(w);
  endtask

  // Present a beat and hold it until it is accepted; returns 1ns after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic l);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = DW'($urandom);
  endtask

  // Scoreboard: compare each word at the negedge before its transfer edge.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      check("word_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        word_t e;
        e = exp_q.pop_front();
        check("word_data", 64'(out_data), 64'(e.data));
        check("word_keep", 64'(out_keep), 64'(e.keep));
        check("word_last", 64'(out_last), 64'(e.last));
        words++;
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      in_data   = DW'($urandom);
      in_valid  = 1'($urandom);
      in_last   = 1'($urandom);
      out_ready = 1'($urandom);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_keep", 64'(out_keep), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
    end
    idle();
    out_ready = 1'b1;
    reset_n   = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Full word, back-to-back
    expect_word(32'hA8B83C15, 4'b1111, 1'b0);
    send(8'h15, 1'b0);
    send(8'h3C, 1'b0);
    send(8'hB8, 1'b0);
    send(8'hA8, 1'b0);
    idle();
    check("fw_latency_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    check("fw_one_cycle", 64'(out_valid), 64'd0);

    // Early flush, then the next beat starts at lane 0
    expect_word(32'h00002211, 4'b0011, 1'b1);
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    check("flush_valid", 64'(out_valid), 64'd1);
    expect_word(32'h66554433, 4'b1111, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    idle();
    @(posedge clk);
    #1;

    // Single-beat packet
    expect_word(32'h0000005A, 4'b0001, 1'b1);
    send(8'h5A, 1'b1);
    idle();
    @(posedge clk);
    #1;

    // Backpressure, then release with a completing beat on the transfer cycle
    out_ready = 1'b0;
    expect_word(32'h40302010, 4'b1111, 1'b0);
    send(8'h10, 1'b0);
    send(8'h20, 1'b0);
    send(8'h30, 1'b0);
    send(8'h40, 1'b0);
    expect_word(32'h00000077, 4'b0001, 1'b1);
    in_data  = 8'h77;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_data_stable", 64'(out_data), 64'h40302010);
      check("bp_keep_stable", 64'(out_keep), 64'hF);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    idle();
    check("bp_no_gap", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;

    // Reset mid-word discards the partial word
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    idle();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    expect_word(32'h04030201, 4'b1111, 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    idle();
    repeat (3) begin
      @(posedge clk);
      #1;
    end

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("word_count", 64'(words), 64'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
